// File: rtl/dtm_pkg.sv
// Shared types and constants for the RISC-V JTAG debug transport module.
//   tap_state_t : the 16 IEEE 1149.1 TAP controller states
//   IR_*        : 5-bit instruction codes recognised by the DTM
//   dmi_op_t    : DMI request operation encoding
//   DMI_STAT_*  : sticky DMI status / response-op values
//   dr_sel_t    : which data register the current instruction selects
package dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPDATE_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPDATE_IR
    } tap_state_t;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2
    } dmi_op_t;

    localparam logic [1:0] DMI_STAT_OK     = 2'd0;
    localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_DTMCS,
        DR_DMI
    } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
//   tck, trst_n  : TCK (rising edge) and async active-low TAP reset
//   tms          : mode select steering the 16-state graph
//   tlr          : controller is in Test-Logic-Reset
//   capture_*/shift_*/update_* : state decodes; the associated DR/IR action
//                  takes place on the rising TCK edge while the strobe is high
module jtag_tap_fsm
    import dtm_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:       state_d = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:       state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:    state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:    state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:    state_d = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:    state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            default:       state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign tlr        = (state_q == TAP_TLR);
    assign capture_dr = (state_q == TAP_CAP_DR);
    assign shift_dr   = (state_q == TAP_SHIFT_DR);
    assign update_dr  = (state_q == TAP_UPDATE_DR);
    assign capture_ir = (state_q == TAP_CAP_IR);
    assign shift_ir   = (state_q == TAP_SHIFT_IR);
    assign update_ir  = (state_q == TAP_UPDATE_IR);

endmodule

// File: rtl/dtm_jtag.sv
// RISC-V debug transport module: JTAG TAP to DMI bridge, TCK domain only.
//   jtag_tck/trst_n/tms/tdi : board JTAG pins (trst_n async active-low)
//   jtag_tdo, jtag_tdo_en   : TDO and its enable, both updated on falling TCK
//   dmi_req_*               : one-outstanding request channel (valid/ready)
//   dmi_resp_*              : response channel; resp_op 0=ok, nonzero=failed
// Holds the IR, a shared DR shift register, dtmcs/dmi capture-update logic
// and the sticky DMI status tracking.
module dtm_jtag
    import dtm_pkg::*;
#(
    parameter int unsigned ABITS    = 7,
    parameter logic [31:0] IDCODE   = 32'h0000_0001,
    parameter int unsigned IR_WIDTH = 5,
    parameter logic [2:0]  IDLE     = 3'd1
) (
    input  logic             jtag_tck,
    input  logic             jtag_trst_n,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             jtag_tdo_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_wdata,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_rdata,
    input  logic [1:0]       dmi_resp_op
);

    localparam int unsigned DMI_W = ABITS + 34;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE_W = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS_W  = IR_WIDTH'(IR_DTMCS);
    localparam logic [IR_WIDTH-1:0] IR_DMI_W    = IR_WIDTH'(IR_DMI);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS_W = IR_WIDTH'(IR_BYPASS);

    logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

    jtag_tap_fsm u_tap (
        .tck        (jtag_tck),
        .trst_n     (jtag_trst_n),
        .tms        (jtag_tms),
        .tlr        (tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
    logic [DMI_W-1:0]    dr_q, dr_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic [1:0]          dmistat_q, dmistat_d;
    logic                pending_q, pending_d;
    logic                discard_q, discard_d;
    logic                req_valid_q, req_valid_d;
    logic                resp_ready_q, resp_ready_d;
    logic [ABITS-1:0]    addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    dmi_op_t             op_q, op_d;

    dr_sel_t             dr_sel;
    logic [31:0]         dtmcs_val;
    logic [1:0]          dmi_status;
    logic                busy;
    logic                req_fire;
    logic                resp_fire;
    logic                hardreset;
    logic [1:0]          upd_op;
    logic [31:0]         upd_data;
    logic [ABITS-1:0]    upd_addr;

    // Unknown instruction codes all fall back to BYPASS.
    always_comb begin
        case (ir_q)
            IR_IDCODE_W: dr_sel = DR_IDCODE;
            IR_DTMCS_W:  dr_sel = DR_DTMCS;
            IR_DMI_W:    dr_sel = DR_DMI;
            IR_BYPASS_W: dr_sel = DR_BYPASS;
            default:     dr_sel = DR_BYPASS;
        endcase
    end

    // A response still owed to a request dropped by hardreset keeps the
    // DMI busy so a second request cannot overlap it.
    assign busy       = pending_q || discard_q;
    assign dmi_status = busy ? DMI_STAT_BUSY : dmistat_q;
    assign dtmcs_val  = {11'b0, 3'd0, 2'b0, 1'b0, IDLE, dmistat_q, 6'(ABITS), 4'd1};

    assign upd_op   = dr_q[1:0];
    assign upd_data = dr_q[33:2];
    assign upd_addr = dr_q[DMI_W-1:34];

    assign req_fire  = req_valid_q && dmi_req_ready;
    assign resp_fire = dmi_resp_valid && resp_ready_q;

    // IR shift and active register
    always_comb begin
        ir_sh_d = ir_sh_q;
        if (capture_ir) begin
            ir_sh_d = IR_WIDTH'(2'b01);
        end else if (shift_ir) begin
            ir_sh_d = {jtag_tdi, ir_sh_q[IR_WIDTH-1:1]};
        end

        ir_d = ir_q;
        if (tlr) begin
            ir_d = IR_IDCODE_W;
        end else if (update_ir) begin
            ir_d = ir_sh_q;
        end
    end

    // One shift register serves every DR; TDI enters at the top bit of the
    // currently selected length so the LSB always sits at bit 0.
    always_comb begin
        dr_d = dr_q;
        if (capture_dr) begin
            case (dr_sel)
                DR_IDCODE: dr_d = DMI_W'(IDCODE | 32'h1);
                DR_DTMCS:  dr_d = DMI_W'(dtmcs_val);
                DR_DMI:    dr_d = {addr_q, data_q, dmi_status};
                default:   dr_d = '0;
            endcase
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE, DR_DTMCS: begin
                    dr_d       = '0;
                    dr_d[31:0] = {jtag_tdi, dr_q[31:1]};
                end
                DR_DMI: dr_d = {jtag_tdi, dr_q[DMI_W-1:1]};
                default: begin
                    dr_d    = '0;
                    dr_d[0] = jtag_tdi;
                end
            endcase
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        if (shift_ir) begin
            tdo_d = ir_sh_q[0];
        end else if (shift_dr) begin
            tdo_d = dr_q[0];
        end
        tdo_en_d = shift_ir || shift_dr;
    end

    // DMI request/response and sticky status. Later assignments take
    // priority: a busy capture overrides a same-cycle failed response, and
    // hardreset overrides everything except the obligation to accept a
    // response the DM already owes.
    always_comb begin
        dmistat_d    = dmistat_q;
        pending_d    = pending_q;
        discard_d    = discard_q;
        req_valid_d  = req_valid_q;
        resp_ready_d = resp_ready_q;
        addr_d       = addr_q;
        data_d       = data_q;
        op_d         = op_q;
        hardreset    = tlr;

        if (resp_fire) begin
            resp_ready_d = 1'b0;
            discard_d    = 1'b0;
            if (!discard_q) begin
                pending_d = 1'b0;
                if (op_q == DMI_READ) begin
                    data_d = dmi_resp_rdata;
                end
                if (dmi_resp_op != 2'd0 && dmistat_q != DMI_STAT_BUSY) begin
                    dmistat_d = DMI_STAT_FAILED;
                end
            end
        end

        if (req_fire) begin
            req_valid_d  = 1'b0;
            resp_ready_d = 1'b1;
        end

        if (capture_dr && dr_sel == DR_DMI && busy) begin
            dmistat_d = DMI_STAT_BUSY;
        end

        if (update_dr && dr_sel == DR_DTMCS) begin
            if (dr_q[16]) begin
                dmistat_d = DMI_STAT_OK;
            end
            if (dr_q[17]) begin
                hardreset = 1'b1;
            end
        end

        // Requests are only launched from a clean status; a sticky error
        // silently drops them until the debugger clears it.
        if (update_dr && dr_sel == DR_DMI &&
            (upd_op == DMI_READ || upd_op == DMI_WRITE) &&
            dmistat_q == DMI_STAT_OK) begin
            if (busy) begin
                dmistat_d = DMI_STAT_BUSY;
            end else begin
                addr_d      = upd_addr;
                data_d      = upd_data;
                op_d        = dmi_op_t'(upd_op);
                pending_d   = 1'b1;
                req_valid_d = 1'b1;
            end
        end

        if (hardreset) begin
            req_valid_d = 1'b0;
            pending_d   = 1'b0;
            dmistat_d   = DMI_STAT_OK;
            if (resp_ready_d) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            ir_q         <= IR_IDCODE_W;
            ir_sh_q      <= '0;
            dr_q         <= '0;
            dmistat_q    <= DMI_STAT_OK;
            pending_q    <= 1'b0;
            discard_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            op_q         <= DMI_NOP;
        end else begin
            ir_q         <= ir_d;
            ir_sh_q      <= ir_sh_d;
            dr_q         <= dr_d;
            dmistat_q    <= dmistat_d;
            pending_q    <= pending_d;
            discard_q    <= discard_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_q         <= op_d;
        end
    end

    always_ff @(negedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign jtag_tdo       = tdo_q;
    assign jtag_tdo_en    = tdo_en_q;
    assign dmi_req_valid  = req_valid_q;
    assign dmi_req_addr   = addr_q;
    assign dmi_req_wdata  = data_q;
    assign dmi_req_op     = op_q;
    assign dmi_resp_ready = resp_ready_q;

endmodule

// File: tb/tb_dtm_jtag.sv
// Directed bench for dtm_jtag: drives the TAP pins, models a simple DM on
// the DMI channel and compares scanned-out values with hand-computed ones.
module tb_dtm_jtag;

    logic        jtag_tck;
    logic        jtag_trst_n;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;
    logic        jtag_tdo_en;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_wdata;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_rdata;
    logic [1:0]  dmi_resp_op;

    dtm_jtag #(
        .ABITS    (7),
        .IDCODE   (32'h0000_0001),
        .IR_WIDTH (5),
        .IDLE     (3'd1)
    ) dut (
        .jtag_tck       (jtag_tck),
        .jtag_trst_n    (jtag_trst_n),
        .jtag_tms       (jtag_tms),
        .jtag_tdi       (jtag_tdi),
        .jtag_tdo       (jtag_tdo),
        .jtag_tdo_en    (jtag_tdo_en),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_wdata  (dmi_req_wdata),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_rdata (dmi_resp_rdata),
        .dmi_resp_op    (dmi_resp_op)
    );

    initial begin
        jtag_tck = 1'b0;
        forever #10 jtag_tck = ~jtag_tck;
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // DM model state
    int          dm_delay = 0;
    logic [31:0] dm_rdata = '0;
    logic [1:0]  dm_op    = '0;
    int          req_cnt  = 0;
    int          resp_cnt = 0;
    logic [6:0]  last_addr;
    logic [1:0]  last_op;
    logic [31:0] last_wdata;

    initial begin
        dmi_resp_valid = 1'b0;
        dmi_resp_rdata = '0;
        dmi_resp_op    = '0;
        forever begin
            @(negedge jtag_tck);
            if (dmi_req_valid && dmi_req_ready) begin
                req_cnt++;
                last_addr  = dmi_req_addr;
                last_op    = dmi_req_op;
                last_wdata = dmi_req_wdata;
                repeat (dm_delay) @(negedge jtag_tck);
                dmi_resp_valid = 1'b1;
                dmi_resp_rdata = dm_rdata;
                dmi_resp_op    = dm_op;
                for (int i = 0; i < 100; i++) begin
                    if (dmi_resp_ready) begin
                        @(negedge jtag_tck);
                        resp_cnt++;
                        break;
                    end
                    @(negedge jtag_tck);
                end
                dmi_resp_valid = 1'b0;
            end
        end
    end

    // Drive TMS/TDI on the falling edge and sample TDO just after it, which
    // reflects the state the following rising edge acts upon.
    task automatic tap_clk(input logic tms, input logic tdi, output logic o, output logic en);
        @(negedge jtag_tck);
        jtag_tms = tms;
        jtag_tdi = tdi;
        #1;
        o  = jtag_tdo;
        en = jtag_tdo_en;
    endtask

    task automatic reset_tap();
        logic o, e;
        for (int i = 0; i < 5; i++) tap_clk(1'b1, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, e);
    endtask

    // From Run-Test/Idle; returns the captured IR bits.
    task automatic shift_ir(input logic [4:0] val, output logic [4:0] cap);
        logic o, e;
        tap_clk(1'b1, 1'b0, o, e);
        tap_clk(1'b1, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, e);
        for (int i = 0; i < 5; i++) begin
            tap_clk(i == 4, val[i], o, e);
            cap[i] = o;
        end
        tap_clk(1'b1, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, e);
    endtask

    // From Run-Test/Idle back to Run-Test/Idle; returns the captured DR bits.
    task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic o, e, en_all, en_pre;
        dout   = '0;
        en_all = 1'b1;
        tap_clk(1'b1, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, e);
        tap_clk(1'b0, 1'b0, o, en_pre);
        for (int i = 0; i < n; i++) begin
            tap_clk(i == n - 1, din[i], o, e);
            dout[i] = o;
            en_all  = en_all & e;
        end
        tap_clk(1'b1, 1'b0, o, e);
        check_eq("tdo_en_capture", {63'b0, en_pre}, 64'd0);
        check_eq("tdo_en_shift", {63'b0, en_all}, 64'd1);
        check_eq("tdo_en_exit1", {63'b0, e}, 64'd0);
        tap_clk(1'b0, 1'b0, o, e);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic scan_dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op, output logic [63:0] cap);
        shift_dr(dmi_word(a, d, op), 41, cap);
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 200; i++) begin
            if (resp_cnt >= target) break;
            @(negedge jtag_tck);
        end
        check_eq("resp_wait", 64'(resp_cnt), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] cap;
        logic [4:0]  ircap;

        jtag_trst_n   = 1'b0;
        jtag_tms      = 1'b1;
        jtag_tdi      = 1'b0;
        dmi_req_ready = 1'b1;
        repeat (2) @(negedge jtag_tck);
        #2;
        check_eq("rst_tdo", {63'b0, jtag_tdo}, 64'd0);
        check_eq("rst_tdo_en", {63'b0, jtag_tdo_en}, 64'd0);
        check_eq("rst_req_valid", {63'b0, dmi_req_valid}, 64'd0);
        check_eq("rst_resp_ready", {63'b0, dmi_resp_ready}, 64'd0);
        jtag_trst_n = 1'b1;

        // IDCODE after five TMS=1 clocks
        reset_tap();
        shift_dr(64'd0, 32, cap);
        check_eq("idcode", cap, 64'h0000_0001);

        // DTMCS capture, IR capture pattern
        shift_ir(5'h10, ircap);
        check_eq("ir_capture", {59'b0, ircap}, 64'd1);
        shift_dr(64'd0, 32, cap);
        check_eq("dtmcs_reset", cap, 64'h0000_1071);

        // BYPASS: captures 0, one-bit delay
        shift_ir(5'h1F, ircap);
        shift_dr(64'd1, 2, cap);
        check_eq("bypass", cap, 64'd2);

        // DMI write, DM responds immediately
        shift_ir(5'h11, ircap);
        dm_delay = 0; dm_rdata = 32'h1234_5678; dm_op = 2'd0;
        scan_dmi(7'h10, 32'h1, 2'd2, cap);
        check_eq("dmi_cap_initial", cap, dmi_word(7'h00, 32'h0, 2'd0));
        wait_resp(1);
        check_eq("wr_addr", 64'(last_addr), 64'h10);
        check_eq("wr_op", 64'(last_op), 64'd2);
        check_eq("wr_wdata", 64'(last_wdata), 64'h1);
        scan_dmi(7'h00, 32'h0, 2'd0, cap);
        check_eq("wr_status", cap, dmi_word(7'h10, 32'h1, 2'd0));

        // Slow read: rescan while pending reports busy, second request dropped
        dm_delay = 20; dm_rdata = 32'hCAFE_F00D;
        scan_dmi(7'h11, 32'h0, 2'd1, cap);
        scan_dmi(7'h12, 32'h0, 2'd1, cap);
        check_eq("busy_status", cap, dmi_word(7'h11, 32'h0, 2'd3));
        wait_resp(2);
        repeat (5) @(negedge jtag_tck);
        #1;
        check_eq("busy_req_count", 64'(req_cnt), 64'd2);
        check_eq("busy_req_addr", 64'(last_addr), 64'h11);
        check_eq("req_valid_after_accept", {63'b0, dmi_req_valid}, 64'd0);
        scan_dmi(7'h00, 32'h0, 2'd0, cap);
        check_eq("busy_sticky", cap, dmi_word(7'h11, 32'hCAFE_F00D, 2'd3));

        // dmireset, then a clean read
        shift_ir(5'h10, ircap);
        shift_dr(64'h0001_0000, 32, cap);
        check_eq("dtmcs_busy", cap, 64'h0000_1C71);
        shift_ir(5'h11, ircap);
        dm_delay = 2; dm_rdata = 32'hDEAD_BEEF; dm_op = 2'd0;
        scan_dmi(7'h11, 32'h0, 2'd1, cap);
        check_eq("cleared_status", cap, dmi_word(7'h11, 32'hCAFE_F00D, 2'd0));
        wait_resp(3);
        scan_dmi(7'h00, 32'h0, 2'd0, cap);
        check_eq("read_deadbeef", cap, dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0));

        // Failed response is sticky and blocks further requests
        dm_delay = 1; dm_rdata = 32'h0BAD_0BAD; dm_op = 2'd2;
        scan_dmi(7'h05, 32'h0, 2'd1, cap);
        wait_resp(4);
        scan_dmi(7'h06, 32'h0, 2'd1, cap);
        check_eq("failed_status", cap, dmi_word(7'h05, 32'h0BAD_0BAD, 2'd2));
        repeat (10) @(negedge jtag_tck);
        #1;
        check_eq("failed_blocks_req", 64'(req_cnt), 64'd4);
        scan_dmi(7'h00, 32'h0, 2'd0, cap);
        check_eq("failed_sticky", cap, dmi_word(7'h05, 32'h0BAD_0BAD, 2'd2));

        // dtmhardreset clears the sticky status
        shift_ir(5'h10, ircap);
        shift_dr(64'h0002_0000, 32, cap);
        check_eq("dtmcs_failed", cap, 64'h0000_1871);
        shift_dr(64'h0, 32, cap);
        check_eq("dtmcs_after_hardreset", cap, 64'h0000_1071);

        // Request held while DM stalls, then trst_n mid-request
        shift_ir(5'h11, ircap);
        dmi_req_ready = 1'b0;
        dm_op = 2'd0;
        scan_dmi(7'h22, 32'h55, 2'd1, cap);
        check_eq("pre_trst_status", cap, dmi_word(7'h05, 32'h0BAD_0BAD, 2'd0));
        @(negedge jtag_tck);
        #1;
        check_eq("req_valid_raised", {63'b0, dmi_req_valid}, 64'd1);
        check_eq("req_addr", 64'(dmi_req_addr), 64'h22);
        repeat (5) @(negedge jtag_tck);
        #1;
        check_eq("req_valid_held", {63'b0, dmi_req_valid}, 64'd1);
        check_eq("req_op_held", 64'(dmi_req_op), 64'd1);
        check_eq("req_wdata_held", 64'(dmi_req_wdata), 64'h55);
        #3;
        jtag_trst_n = 1'b0;
        #1;
        check_eq("trst_req_valid", {63'b0, dmi_req_valid}, 64'd0);
        check_eq("trst_resp_ready", {63'b0, dmi_resp_ready}, 64'd0);
        @(negedge jtag_tck);
        #2;
        jtag_trst_n   = 1'b1;
        dmi_req_ready = 1'b1;
        begin
            logic o, e;
            tap_clk(1'b0, 1'b0, o, e);
        end
        shift_dr(64'd0, 32, cap);
        check_eq("trst_ir_idcode", cap, 64'h0000_0001);
        check_eq("trst_req_count", 64'(req_cnt), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
